// File: rtl/fsm_ab_stim_driver.sv
`default_nettype none
// ============================================================================
// Module   : fsm_ab_stim_driver
// Purpose  : Serially drives a latched (a,b) symbol sequence into an a/b-input
//            FSM and counts asserted cycles of its Mealy (y0) and Moore (y1)
//            outputs.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_ab_stim_driver #(
    parameter int LEN  = 8,
    parameter int HOLD = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [LEN-1:0] seq_a,
    input  logic [LEN-1:0] seq_b,
    input  logic           y0_in,
    input  logic           y1_in,
    output logic           a_out,
    output logic           b_out,
    output logic           busy,
    output logic           done,
    output logic [7:0]     y0_cnt,
    output logic [7:0]     y1_cnt
);

    localparam int                 c_IDX_W     = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(LEN - 1);
    localparam logic [7:0]         c_HOLD_LAST = 8'(HOLD - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [LEN-1:0]     r_seq_a;
    logic [LEN-1:0]     r_seq_b;
    logic [c_IDX_W-1:0] r_idx;
    logic [7:0]         r_hold_cnt;
    logic [c_IDX_W-1:0] w_next_idx;

    assign w_next_idx = r_idx + 1'b1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_seq_a    <= '0;
            r_seq_b    <= '0;
            r_idx      <= '0;
            r_hold_cnt <= '0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            y0_cnt     <= '0;
            y1_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        r_seq_a    <= seq_a;
                        r_seq_b    <= seq_b;
                        r_idx      <= '0;
                        r_hold_cnt <= '0;
                        y0_cnt     <= '0;
                        y1_cnt     <= '0;
                        // Symbol 0 goes straight from the inputs so it appears the cycle after accept
                        a_out      <= seq_a[0];
                        b_out      <= seq_b[0];
                        busy       <= 1'b1;
                        r_state    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (y0_in) y0_cnt <= sat_inc(y0_cnt);
                    if (y1_in) y1_cnt <= sat_inc(y1_cnt);
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_hold_cnt <= '0;
                        if (r_idx == c_IDX_LAST) begin
                            a_out   <= 1'b0;
                            b_out   <= 1'b0;
                            r_state <= S_FLUSH;
                        end else begin
                            r_idx <= w_next_idx;
                            a_out <= r_seq_a[w_next_idx];
                            b_out <= r_seq_b[w_next_idx];
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                S_FLUSH: begin
                    // Moore output settles one cycle after the last symbol
                    if (y1_in) y1_cnt <= sat_inc(y1_cnt);
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
